operand_entry_ctrl: RTL and testbench
=====================================

Name: operand_entry_ctrl

Overview:
- Front-end controller for the six-bit add/subtract display path. It conditions the raw push-button: two-flop synchronizer, debounce, then rising-edge detect.
- It steps the user through enter-A, enter-B and show-answer phases and latches the switch operands and the add/sub mode at each press.
- It drives the phase LEDs and hands registered operands plus a result-valid strobe to the arithmetic/hex-display datapath.

Parameters:
- WIDTH, 6, operand width in bits for A/B and op_a/op_b.
- DEBOUNCE_CYCLES, 4, consecutive cycles the synchronized button must differ from the debounced level before that level flips. Use 4 for simulation; the board build overrides it (e.g. 500000). Minimum legal value is 1.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset; forces every register to its reset value immediately.
- A  in  WIDTH  operand-A switches, unsynchronized; sampled only at a press.
- B  in  WIDTH  operand-B switches, unsynchronized; sampled only at a press.
- Add_Sub  in  1  mode switch: 0 = add, 1 = subtract; sampled with B.
- button  in  1  raw push-button, active-high, asynchronous and bouncy.
- op_a  out  WIDTH  latched operand A.
- op_b  out  WIDTH  latched operand B.
- op_sub  out  1  latched mode.
- load_a  out  1  one-cycle pulse in the cycle after op_a updates.
- result_valid  out  1  one-cycle pulse in the cycle after op_b and op_sub update.
- A_LED  out  1  high while in ENTER_A.
- B_LED  out  1  high while in ENTER_B.
- answer_LED  out  1  high while in SHOW.
- state  out  2  current state code, for debug and bench checking.

Behaviour:
Reset values:
- state = ENTER_A (2'b00), so A_LED = 1, B_LED = 0, answer_LED = 0.
- op_a = 0, op_b = 0, op_sub = 0, load_a = 0, result_valid = 0.
- Synchronizer flops, debounced level, edge register and debounce counter all = 0.

Button conditioning:
- Synchronizer: s1 <= button; s2 <= s1.
- Debounce counter while s2 != db: increment each cycle. When the counter reaches DEBOUNCE_CYCLES-1 with s2 still != db, then db <= s2 and the counter clears.
- Counter while s2 == db: clears to 0. Any bounce therefore restarts the count.
- Edge detect: db_d <= db; press = db & ~db_d, combinational and high for exactly one cycle.
- Latency: if button is first sampled high at edge k and held, s2 rises after edge k+1 and db rises after edge k+1+DEBOUNCE_CYCLES. press is high during the following cycle, and the state update happens at edge k+2+DEBOUNCE_CYCLES.
- Pulses shorter than DEBOUNCE_CYCLES synchronized cycles produce no press.
- Release is debounced by the same rule and never generates a press.
- Holding the button produces exactly one press.

FSM (Moore LEDs; transitions only on press):
- ENTER_A (00): on press, op_a <= A and next state is ENTER_B. load_a is registered high for the next cycle.
- ENTER_B (01): on press, op_b <= B and op_sub <= Add_Sub, and next state is SHOW. result_valid is registered high for the next cycle.
- SHOW (10): on press, next state is ENTER_A. op_a, op_b and op_sub hold.
- Code 11 is illegal and returns to ENTER_A on the next edge with no pulses.
- Operands change only at the capturing press. Switch activity at any other time has no effect.
- Exactly one LED is high at all times.

Reset mid-operation:
- Asynchronous assertion clears the counter and db.
- A press that was in progress is lost.
- No pulse is emitted during reset or on the first cycle after deassertion.

Test Plan:
- Reset with button=0: after deassertion, state=00, A_LED=1, op_a=op_b=0, op_sub=0, and no pulses for 20 cycles.
- Full sequence, DEBOUNCE_CYCLES=4: set A=15 and hold button 10 cycles, then release 10 cycles.
  - Required: op_a=15, load_a is one pulse 6 edges after the first high sample, state=01.
  - Then set B=8, Add_Sub=0 and press: op_b=8, op_sub=0, one result_valid pulse, answer_LED=1.
  - Press again: state=00, op_a=15, op_b=8 retained.
- Bounce rejection: in ENTER_A, toggle button 1,0,1,0 on consecutive cycles, then hold 0. Required: no press, state stays 00, op_a unchanged.
- Long hold: press and hold button for 50 cycles in ENTER_B with B=10 and Add_Sub=1. Required: exactly one result_valid, op_b=10, op_sub=1, state=10 and not advancing further.
- Capture isolation: after op_a=14 is captured, change A to 3 while in ENTER_B and SHOW. Required: op_a stays 14 until the next ENTER_A press.
- Reset mid-debounce: assert reset 2 cycles into a held press in ENTER_B. Required: immediate state=00 and ops=0. After release with the button still held, no press occurs until the button is released and pressed again.

Source files
------------

// File: rtl/operand_entry_ctrl.sv
// Push-button conditioning (sync, debounce, rising edge) and the A/B/answer entry
// sequencer that latches switch operands for the add/subtract display datapath.
module operand_entry_ctrl #(
    parameter int WIDTH           = 6,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Add_Sub,
    input  logic             button,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic             op_sub,
    output logic             load_a,
    output logic             result_valid,
    output logic             A_LED,
    output logic             B_LED,
    output logic             answer_LED,
    output logic [1:0]       state
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ENTER_A = 2'b00,
        ENTER_B = 2'b01,
        SHOW    = 2'b10,
        ILLEGAL = 2'b11
    } state_e;

    logic          sync1_q, sync2_q;
    logic          db_q, db_d, db_prev_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    warm_q;
    logic          arm_q;
    logic          press;

    state_e state_q, state_d;

    logic [WIDTH-1:0] op_a_q, op_b_q;
    logic             op_sub_q, load_a_q, result_valid_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            db_q      <= 1'b0;
            db_prev_q <= 1'b0;
            cnt_q     <= '0;
            warm_q    <= '0;
            arm_q     <= 1'b0;
        end else begin
            sync1_q   <= button;
            sync2_q   <= sync1_q;
            db_q      <= db_d;
            db_prev_q <= db_q;
            cnt_q     <= cnt_d;
            warm_q    <= {warm_q[0], 1'b1};
            // Arm only once a real (post-reset) low has reached sync2, so a
            // button held through reset cannot produce a press on its own.
            arm_q     <= arm_q | (warm_q[1] & ~sync2_q);
        end
    end

    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    assign press = db_q & ~db_prev_q & arm_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ENTER_A;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ENTER_A: if (press) state_d = ENTER_B;
            ENTER_B: if (press) state_d = SHOW;
            SHOW:    if (press) state_d = ENTER_A;
            default:            state_d = ENTER_A;
        endcase
    end

    always_comb begin
        A_LED      = (state_q == ENTER_A);
        B_LED      = (state_q == ENTER_B);
        answer_LED = (state_q == SHOW);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_a_q         <= '0;
            op_b_q         <= '0;
            op_sub_q       <= 1'b0;
            load_a_q       <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            load_a_q       <= press && (state_q == ENTER_A);
            result_valid_q <= press && (state_q == ENTER_B);
            if (press && (state_q == ENTER_A)) begin
                op_a_q <= A;
            end
            if (press && (state_q == ENTER_B)) begin
                op_b_q   <= B;
                op_sub_q <= Add_Sub;
            end
        end
    end

    assign op_a         = op_a_q;
    assign op_b         = op_b_q;
    assign op_sub       = op_sub_q;
    assign load_a       = load_a_q;
    assign result_valid = result_valid_q;
    assign state        = state_q;

endmodule

// File: tb/tb_operand_entry_ctrl.sv
// Bench for operand_entry_ctrl: directed test-plan scenarios plus random button and
// switch activity, all checked each cycle against a sample-history reference model.
module tb_operand_entry_ctrl;

    localparam int W   = 6;
    localparam int DEB = 4;

    logic         clk;
    logic         reset;
    logic [W-1:0] A, B;
    logic         Add_Sub, button;
    logic [W-1:0] op_a, op_b;
    logic         op_sub, load_a, result_valid, A_LED, B_LED, answer_LED;
    logic [1:0]   state;

    operand_entry_ctrl #(.WIDTH(W), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk(clk), .reset(reset), .A(A), .B(B), .Add_Sub(Add_Sub), .button(button),
        .op_a(op_a), .op_b(op_b), .op_sub(op_sub), .load_a(load_a),
        .result_valid(result_valid), .A_LED(A_LED), .B_LED(B_LED),
        .answer_LED(answer_LED), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    bit          chk_en   = 0;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: raw button samples per edge; a press is a rising step of a
    // level that only flips after DEB consecutive synchronized samples disagree.
    int unsigned  m_state;
    logic [W-1:0] m_op_a, m_op_b;
    bit           m_sub, m_load, m_rv;
    bit           m_db, m_seen_low, m_press;
    bit           bq[$];
    bit           s2q[$];
    bit           s2now, s2_real, db_before, all_diff;

    function automatic void model_clear();
        m_state = 0; m_op_a = '0; m_op_b = '0; m_sub = 0;
        m_load = 0; m_rv = 0; m_db = 0; m_seen_low = 0; m_press = 0;
        bq.delete(); s2q.delete();
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            m_load = 0;
            m_rv   = 0;
            if (m_press) begin
                case (m_state)
                    0: begin m_op_a = A; m_state = 1; m_load = 1; end
                    1: begin m_op_b = B; m_sub = Add_Sub; m_state = 2; m_rv = 1; end
                    default: m_state = 0;
                endcase
            end
            s2_real = (bq.size() >= 2);
            s2now   = s2_real ? bq[bq.size()-2] : 1'b0;
            s2q.push_back(s2now);
            bq.push_back(button);
            db_before = m_db;
            if (s2q.size() >= DEB) begin
                all_diff = 1;
                for (int i = 0; i < DEB; i++)
                    if (s2q[s2q.size()-1-i] == m_db) all_diff = 0;
                if (all_diff) m_db = ~m_db;
            end
            if (s2_real && !s2now) m_seen_low = 1;
            m_press = m_db && !db_before && m_seen_low;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("state", state, m_state);
            check("op_a", op_a, m_op_a);
            check("op_b", op_b, m_op_b);
            check("op_sub", op_sub, m_sub);
            check("pulses", {load_a, result_valid}, {m_load, m_rv});
            check("leds", {A_LED, B_LED, answer_LED},
                  {m_state == 0, m_state == 1, m_state == 2});
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        model_clear();
        repeat (n) step();
        reset = 1'b0;
    endtask

    int unsigned ld_cnt, rv_cnt;

    task automatic press_release(input int hold, input int rel);
        ld_cnt = 0;
        rv_cnt = 0;
        button = 1'b1;
        repeat (hold) begin step(); ld_cnt += load_a; rv_cnt += result_valid; end
        button = 1'b0;
        repeat (rel) begin step(); ld_cnt += load_a; rv_cnt += result_valid; end
    endtask

    int ld_at;
    int len;

    initial begin
        reset = 1'b1; A = '0; B = '0; Add_Sub = 1'b0; button = 1'b0;
        model_clear();
        step();
        chk_en = 1;
        do_reset(3);

        // Idle after reset
        ld_cnt = 0; rv_cnt = 0;
        repeat (20) begin step(); ld_cnt += load_a; rv_cnt += result_valid; end
        check("rst_state", state, 0);
        check("rst_aled", A_LED, 1);
        check("rst_pulses", ld_cnt + rv_cnt, 0);

        // Capture A with latency measurement
        A = 6'd15;
        ld_at = -1;
        button = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (load_a && ld_at < 0) ld_at = i;
        end
        button = 1'b0;
        repeat (10) step();
        check("load_a_latency", ld_at, 7);
        check("opa_15", op_a, 15);
        check("state_b", state, 1);

        B = 6'd8; Add_Sub = 1'b0;
        press_release(10, 10);
        check("opb_8", op_b, 8);
        check("opsub_0", op_sub, 0);
        check("rv_once", rv_cnt, 1);
        check("ans_led", answer_LED, 1);

        press_release(10, 10);
        check("back_a", state, 0);
        check("keep_opa", op_a, 15);
        check("keep_opb", op_b, 8);

        // Bounce shorter than the debounce window
        A = 6'd40;
        button = 1'b1; step();
        button = 1'b0; step();
        button = 1'b1; step();
        button = 1'b0; step();
        repeat (15) step();
        check("bounce_state", state, 0);
        check("bounce_opa", op_a, 15);

        // Long hold in ENTER_B plus capture isolation
        A = 6'd14;
        press_release(10, 10);
        check("opa_14", op_a, 14);
        A = 6'd3; B = 6'd10; Add_Sub = 1'b1;
        press_release(50, 10);
        check("long_rv", rv_cnt, 1);
        check("long_opb", op_b, 10);
        check("long_sub", op_sub, 1);
        check("long_state", state, 2);
        check("iso_opa_show", op_a, 14);
        press_release(10, 10);
        check("iso_opa_a", op_a, 14);
        press_release(10, 10);
        check("opa_3", op_a, 3);

        // Reset two cycles into a held press
        button = 1'b1;
        repeat (2) step();
        reset = 1'b1;
        model_clear();
        #1;
        check("midrst_state", state, 0);
        check("midrst_opa", op_a, 0);
        repeat (2) step();
        reset = 1'b0;
        ld_cnt = 0;
        repeat (30) begin step(); ld_cnt += load_a; end
        check("held_no_press", state, 0);
        check("held_no_load", ld_cnt, 0);
        button = 1'b0;
        repeat (10) step();
        press_release(10, 10);
        check("repress_state", state, 1);

        // Random button activity with moving switches
        for (int s = 0; s < 220; s++) begin
            button = ~button;
            len = int'($urandom_range(1, 12));
            if ($urandom_range(0, 29) == 0) do_reset(int'($urandom_range(1, 3)));
            for (int j = 0; j < len; j++) begin
                A = W'($urandom);
                B = W'($urandom);
                Add_Sub = 1'($urandom);
                step();
            end
        end
        button = 1'b0;
        repeat (15) step();

        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
